// File: rtl/johnson_decoder.sv
// johnson_decoder: decodes a 4-bit Johnson code to a ring position, tracking direction, net steps and errors
module johnson_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [3:0]       code,
   input  logic             err_clr,
   output logic [2:0]       pos,
   output logic             pos_valid,
   output logic             step,
   output logic             dir,
   output logic             err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] steps
);
   typedef enum logic {UNLOCKED, LOCKED} state_t;
   state_t state;
   logic legal, fwd, rev, err_n;
   logic [2:0] idx;
   always_comb begin
      legal = 1'b1;
      idx = 3'd0;
      case (code)
         4'b0000: idx = 3'd0;
         4'b0001: idx = 3'd1;
         4'b0011: idx = 3'd2;
         4'b0111: idx = 3'd3;
         4'b1111: idx = 3'd4;
         4'b1110: idx = 3'd5;
         4'b1100: idx = 3'd6;
         4'b1000: idx = 3'd7;
         default: legal = 1'b0;
      endcase
   end
   assign fwd = idx == 3'(pos + 3'd1);
   assign rev = idx == 3'(pos - 3'd1);
   // a legal move other than hold or +/-1 while locked is a skip
   assign err_n = in_valid && (!legal || (state == LOCKED && idx != pos && !fwd && !rev));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= UNLOCKED;
         pos        <= 3'd0;
         pos_valid  <= 1'b0;
         step       <= 1'b0;
         dir        <= 1'b0;
         err        <= 1'b0;
         err_sticky <= 1'b0;
         steps      <= '0;
      end else begin
         step       <= 1'b0;
         err        <= err_n;
         err_sticky <= err_n || (err_sticky && !err_clr);
         if (in_valid) begin
            if (!legal) begin
               state     <= UNLOCKED;
               pos_valid <= 1'b0;
            end else if (state == UNLOCKED) begin
               state     <= LOCKED;
               pos       <= idx;
               pos_valid <= 1'b1;
            end else if (idx != pos) begin
               pos <= idx;
               if (fwd) begin
                  step  <= 1'b1;
                  dir   <= 1'b0;
                  steps <= steps + 1'b1;
               end else if (rev) begin
                  step  <= 1'b1;
                  dir   <= 1'b1;
                  steps <= steps - 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder: directed vectors checked against a ring-arithmetic model every cycle plus literal expectations
module tb_johnson_decoder;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, err_clr = 1'b0;
   logic [3:0] code = 4'd0;
   logic [2:0] pos;
   logic pos_valid, step, dir, err, err_sticky;
   logic [7:0] steps;
   int passed = 0, total = 0;
   bit cmp_en = 1'b0;

   johnson_decoder #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .code(code), .err_clr(err_clr),
      .pos(pos), .pos_valid(pos_valid), .step(step), .dir(dir), .err(err),
      .err_sticky(err_sticky), .steps(steps)
   );

   always #5 clk = ~clk;

   logic [3:0] tbl [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
   bit m_lock, m_pv, m_step, m_dir, m_err, m_stk;
   int m_pos, m_steps, k, d;

   function automatic int lookup(logic [3:0] c);
      for (int i = 0; i < 8; i++) if (tbl[i] == c) return i;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lock = 0; m_pv = 0; m_step = 0; m_dir = 0; m_err = 0; m_stk = 0; m_pos = 0; m_steps = 0;
      end else begin
         k = lookup(code);
         m_step = 0;
         m_err = 0;
         if (in_valid) begin
            if (k < 0) begin
               m_err = 1; m_lock = 0; m_pv = 0;
            end else if (!m_lock) begin
               m_lock = 1; m_pv = 1; m_pos = k;
            end else begin
               d = (k - m_pos + 8) % 8;
               if (d == 1) begin m_step = 1; m_dir = 0; m_steps = (m_steps + 1) % 256; end
               else if (d == 7) begin m_step = 1; m_dir = 1; m_steps = (m_steps + 255) % 256; end
               else if (d != 0) m_err = 1;
               m_pos = k;
            end
         end
         m_stk = m_err || (m_stk && !err_clr);
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk)
      if (cmp_en)
         chk("model", {pos, pos_valid, step, dir, err, err_sticky, steps},
             {3'(m_pos), m_pv, m_step, m_dir, m_err, m_stk, 8'(m_steps)});

   task automatic apply(logic v, logic [3:0] c);
      in_valid = v;
      code = c;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] seq [9] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};

   initial begin
      @(posedge clk); @(posedge clk); #1;
      chk("reset", {pos, pos_valid, step, dir, err, err_sticky, steps}, 0);
      rst_n = 1'b1;
      cmp_en = 1'b1;
      apply(1, seq[0]);
      chk("lock0", {pos, pos_valid, step, err, steps}, {3'd0, 1'b1, 1'b0, 1'b0, 8'd0});
      for (int i = 1; i < 9; i++) begin
         apply(1, seq[i]);
         chk("fwd_step", {step, dir, err, pos}, {1'b1, 1'b0, 1'b0, 3'(i % 8)});
      end
      chk("fwd_steps", steps, 8'd8);
      apply(1, 4'b0001);
      apply(1, 4'b0011);
      chk("at2", {pos, steps}, {3'd2, 8'd10});
      apply(1, 4'b0001);
      apply(1, 4'b0000);
      apply(1, 4'b1000);
      chk("rev_wrap", {pos, step, dir, steps}, {3'd7, 1'b1, 1'b1, 8'd7});
      apply(1, 4'b0000);
      apply(1, 4'b0001);
      apply(1, 4'b0111);
      chk("skip", {pos, pos_valid, step, err, err_sticky, steps}, {3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 8'd9});
      err_clr = 1'b1;
      apply(1, 4'b0111);
      err_clr = 1'b0;
      chk("clr", {err, err_sticky}, 2'b00);
      apply(1, 4'b0101);
      chk("illegal", {pos, pos_valid, err, step, err_sticky}, {3'd3, 1'b0, 1'b1, 1'b0, 1'b1});
      apply(1, 4'b1111);
      chk("relock", {pos, pos_valid, step, err, steps}, {3'd4, 1'b1, 1'b0, 1'b0, 8'd9});
      apply(1, 4'b1110);
      chk("relock_step", {pos, step, dir, steps}, {3'd5, 1'b1, 1'b0, 8'd10});
      apply(1, 4'b0101);
      apply(1, 4'b0001);
      chk("lock1", {pos, pos_valid, step, steps}, {3'd1, 1'b1, 1'b0, 8'd10});
      apply(0, 4'b0001);
      for (int i = 0; i < 3; i++) begin
         apply(0, 4'b0011);
         chk("idle_hold", {pos, step, err, steps}, {3'd1, 1'b0, 1'b0, 8'd10});
      end
      apply(1, 4'b0011);
      chk("valid_step", {pos, step, dir, steps}, {3'd2, 1'b1, 1'b0, 8'd11});
      #3 rst_n = 1'b0;
      #1 chk("async_rst", {pos, pos_valid, step, dir, err, err_sticky, steps}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      apply(1, 4'b0011);
      chk("post_rst_lock", {pos, pos_valid, step, steps}, {3'd2, 1'b1, 1'b0, 8'd0});
      apply(1, 4'b0001);
      chk("underflow", {pos, step, dir, steps}, {3'd1, 1'b1, 1'b1, 8'hFF});
      err_clr = 1'b1;
      apply(1, 4'b0101);
      err_clr = 1'b0;
      chk("set_wins", {err, err_sticky}, 2'b11);
      apply(0, 4'b0000);
      @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/johnson_decoder.md
Name: johnson_decoder

Overview:
Receiving end of the 4-bit Johnson (twisted-ring) counter interface. Samples a 4-bit Johnson code on a qualifying strobe and decodes it to a 3-bit ring position. Tracks each step and infers its direction (forward/reverse), keeping a wrapping net step count. Flags illegal codes and skipped positions, so downstream logic and LED drivers can confirm the counter is sequencing correctly.

Parameters:
CNT_W, 8, width of net step counter (two's complement, wraps)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  sample strobe; code is evaluated only in cycles where in_valid=1
code  input  4  Johnson code from counter (same clock domain)
err_clr  input  1  clears err_sticky
pos  output  3  decoded ring position 0..7
pos_valid  output  1  1 while locked to a legal sequence
step  output  1  one-cycle pulse on a legal single-position move
dir  output  1  direction of last step: 0 = forward, 1 = reverse
err  output  1  one-cycle pulse on illegal code or skip
err_sticky  output  1  latched error flag
steps  output  CNT_W  net step count (+1 forward, -1 reverse, mod 2^CNT_W)

Behaviour:
- Decode table, code to index:
  - 0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7.
  - The remaining 8 codes are illegal.
- All outputs are registered. Response appears in the cycle after the in_valid sample, i.e. 1-cycle latency.
- Reset (rst_n low, asynchronous): state=UNLOCKED, pos=0, pos_valid=0, step=0, dir=0, err=0, err_sticky=0, steps=0.
- in_valid=0: state, pos, dir and steps hold; step=0 and err=0 next cycle.
- FSM has 2 states, UNLOCKED and LOCKED.
- UNLOCKED + legal code:
  - pos := idx, pos_valid := 1, go to LOCKED.
  - No step pulse, steps unchanged.
- UNLOCKED + illegal code: err pulse, stay UNLOCKED, pos holds.
- LOCKED + legal idx == pos: hold, no pulse.
- LOCKED + idx == (pos+1) mod 8: step=1, dir=0, steps+1, pos := idx.
- LOCKED + idx == (pos-1) mod 8: step=1, dir=1, steps-1, pos := idx.
- LOCKED + any other legal idx (skip of 2..4 positions):
  - err pulse, pos := idx (resync), stay LOCKED.
  - No step; dir and steps unchanged.
- LOCKED + illegal code:
  - err pulse, go to UNLOCKED, pos_valid := 0.
  - pos holds last legal value.
- Wrap rules:
  - 7 -> 0 is forward; 0 -> 7 is reverse.
  - steps wraps silently: 0 - 1 = 2^CNT_W - 1; max + 1 = 0.
- err_sticky: set on any err pulse, cleared by err_clr. If err and err_clr occur in the same cycle, set wins.
- step and err are never both 1 in the same cycle.
- rst_n asserted mid-sequence: immediate return to the reset values. The first legal sample after release only locks; it does not step.

Test Plan:
- Reset, then in_valid=1 with codes 0000,0001,0011,0111,1111,1110,1100,1000,0000 on consecutive cycles -> first sample locks pos=0 with no step; then 8 step pulses, dir=0, pos 1..7 then 0, steps=8.
- Locked at pos=2 (0011), apply 0001,0000,1000 -> 3 step pulses, dir=1, pos=1,0,7, steps decrements by 3; 0->7 counts as reverse.
- Locked at pos=1, apply 0111 (skip to 3) -> err pulse, pos=3, no step, steps unchanged, err_sticky=1, pos_valid stays 1.
- Locked, apply illegal 0101 -> err pulse, pos_valid=0, pos holds. Next 1111 -> relock pos=4 with no step; next 1110 -> step, dir=0, pos=5.
- Toggle in_valid low while code changes, 0001 -> 0011 held 3 cycles -> no outputs change. Raise in_valid on 0011 -> single step to pos=2.
- CNT_W=8, start steps=0, one reverse step -> steps=8'hFF. Assert err_clr coincident with a new err -> err_sticky remains 1. Assert rst_n low mid-run -> all outputs 0 asynchronously.
